// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB requester: FSM states, slave-select codes and default widths.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_NONE = 2'd0;
  localparam sel_t SEL_S1   = 2'd1;
  localparam sel_t SEL_S2   = 2'd2;
  localparam sel_t SEL_S3   = 2'd3;

  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_TIMEOUT = 255;

endpackage

// File: rtl/apb_master_if.sv
// Host command/response port plus the shared APB bus, seen from the requester (master) or its environment (slave).
interface apb_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_id;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  logic [1:0]        sel;
  logic              enable;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    input  req_valid, req_write, req_id, req_addr, req_wdata, rsp_ready, rdata, ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, sel, enable, write, addr, wdata
  );

  modport slave (
    output req_valid, req_write, req_id, req_addr, req_wdata, rsp_ready, rdata, ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, sel, enable, write, addr, wdata
  );
endinterface

// File: rtl/apb_master.sv
// APB requester: one host command at a time through SETUP/ACCESS, with a bounded wait for slave ready.
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  apb_master_if.master  bus
);
  import apb_pkg::*;

  // Keep at least one counter bit so TIMEOUT=0 (no abort) still elaborates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t             state;
  sel_t               sel_r;
  logic               enable_r;
  logic               write_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic               rsp_valid_r;
  logic [DATA_W-1:0]  rsp_rdata_r;
  logic               rsp_error_r;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   wait_cnt_nxt;
  logic               timed_out;

  always_comb begin
    wait_cnt_nxt = wait_cnt + CNT_W'(1);
    timed_out    = (TIMEOUT != 0) && (wait_cnt_nxt == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel_r       <= SEL_NONE;
      enable_r    <= 1'b0;
      write_r     <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_error_r <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_id != SEL_NONE) begin
              // Bus outputs load on the accept edge so SETUP is visible for exactly one cycle.
              sel_r    <= bus.req_id;
              write_r  <= bus.req_write;
              addr_r   <= bus.req_addr;
              wdata_r  <= bus.req_wdata;
              enable_r <= 1'b0;
              wait_cnt <= '0;
              state    <= SETUP;
            end else begin
              rsp_valid_r <= 1'b1;
              rsp_error_r <= 1'b1;
              rsp_rdata_r <= '0;
              state       <= RESP;
            end
          end
        end

        SETUP: begin
          enable_r <= 1'b1;
          state    <= ACCESS;
        end

        ACCESS: begin
          if (bus.ready) begin
            rsp_rdata_r <= write_r ? '0 : bus.rdata;
            rsp_error_r <= 1'b0;
            rsp_valid_r <= 1'b1;
            sel_r       <= SEL_NONE;
            enable_r    <= 1'b0;
            state       <= RESP;
          end else if (timed_out) begin
            rsp_rdata_r <= '0;
            rsp_error_r <= 1'b1;
            rsp_valid_r <= 1'b1;
            sel_r       <= SEL_NONE;
            enable_r    <= 1'b0;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt_nxt;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_error = rsp_error_r;
  assign bus.sel       = sel_r;
  assign bus.enable    = enable_r;
  assign bus.write     = write_r;
  assign bus.addr      = addr_r;
  assign bus.wdata     = wdata_r;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT=4): write, read, timeout, invalid id, backpressure, reset mid-access.
module tb_apb_master;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  apb_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge; inputs are driven and outputs sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_id    = 2'd0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    bus.rsp_ready = 1'b0;
    bus.rdata     = 8'h00;
    bus.ready     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++; if (bus.sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", bus.sel); end
    checks++; if (bus.enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", bus.enable); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 8'h00) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=00", bus.rsp_rdata); end
    checks++; if (bus.rsp_error !== 1'b0) begin failures++; $display("FAIL reset_rsp_error got=%b exp=0", bus.rsp_error); end
    checks++; if (bus.addr !== 8'h00 || bus.wdata !== 8'h00 || bus.write !== 1'b0) begin
      failures++; $display("FAIL reset_bus got addr=%h wdata=%h write=%b exp 00/00/0", bus.addr, bus.wdata, bus.write);
    end
    reset = 1'b0;
    tick();
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_write();
    int en_cnt;
    en_cnt = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_id = 2'd1;
    bus.req_addr = 8'h10; bus.req_wdata = 8'hA5;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL wr_req_ready got=%b exp=1", bus.req_ready); end
    tick();
    idle_inputs();
    // SETUP
    checks++; if (bus.sel !== 2'd1 || bus.write !== 1'b1 || bus.enable !== 1'b0) begin
      failures++; $display("FAIL wr_setup got sel=%0d write=%b enable=%b exp 1/1/0", bus.sel, bus.write, bus.enable);
    end
    checks++; if (bus.addr !== 8'h10 || bus.wdata !== 8'hA5) begin
      failures++; $display("FAIL wr_setup_data got addr=%h wdata=%h exp 10/A5", bus.addr, bus.wdata);
    end
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL wr_busy_req_ready got=%b exp=0", bus.req_ready); end
    tick();
    if (bus.enable === 1'b1) en_cnt++;
    tick();
    if (bus.enable === 1'b1) en_cnt++;
    tick();
    if (bus.enable === 1'b1) en_cnt++;
    checks++; if (bus.sel !== 2'd1 || bus.addr !== 8'h10 || bus.wdata !== 8'hA5 || bus.write !== 1'b1) begin
      failures++; $display("FAIL wr_access_hold got sel=%0d addr=%h wdata=%h write=%b exp 1/10/A5/1", bus.sel, bus.addr, bus.wdata, bus.write);
    end
    // Slave raises ready after two wait cycles; rdata must not leak into a write response.
    bus.ready = 1'b1; bus.rdata = 8'hFF;
    tick();
    idle_inputs();
    if (bus.enable === 1'b1) en_cnt++;
    checks++; if (en_cnt !== 3) begin failures++; $display("FAIL wr_enable_cycles got=%0d exp=3", en_cnt); end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b0 || bus.rsp_rdata !== 8'h00) begin
      failures++; $display("FAIL wr_rsp got valid=%b err=%b rdata=%h exp 1/0/00", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata);
    end
    checks++; if (bus.sel !== 2'd0) begin failures++; $display("FAIL wr_sel_release got=%0d exp=0", bus.sel); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL wr_done got rsp_valid=%b req_ready=%b exp 0/1", bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_read();
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_id = 2'd2; bus.req_addr = 8'h3C;
    // Ready already high before ACCESS must be ignored until ACCESS; rsp_ready high on RESP entry.
    bus.ready = 1'b1; bus.rdata = 8'h5A; bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.enable !== 1'b0 || bus.sel !== 2'd2) begin
      failures++; $display("FAIL rd_setup got enable=%b sel=%0d exp 0/2", bus.enable, bus.sel);
    end
    tick();
    checks++; if (bus.enable !== 1'b1 || bus.addr !== 8'h3C || bus.write !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rd_access got enable=%b addr=%h write=%b rsp_valid=%b exp 1/3C/0/0", bus.enable, bus.addr, bus.write, bus.rsp_valid);
    end
    tick();
    bus.ready = 1'b0; bus.rdata = 8'h00;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'h5A || bus.rsp_error !== 1'b0) begin
      failures++; $display("FAIL rd_rsp got valid=%b rdata=%h err=%b exp 1/5A/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_error);
    end
    checks++; if (bus.sel !== 2'd0 || bus.enable !== 1'b0) begin
      failures++; $display("FAIL rd_release got sel=%0d enable=%b exp 0/0", bus.sel, bus.enable);
    end
    tick();
    bus.rsp_ready = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL rd_done got rsp_valid=%b req_ready=%b exp 0/1", bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_timeout();
    int en_cnt;
    bit seen;
    en_cnt = 0;
    seen = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_id = 2'd3; bus.req_addr = 8'h55;
    bus.rdata = 8'h77;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.rsp_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.enable === 1'b1) en_cnt++;
    end
    checks++; if (!seen) begin failures++; $display("FAIL to_rsp_wait got=no_rsp exp=rsp_within_20"); end
    checks++; if (en_cnt !== 4) begin failures++; $display("FAIL to_enable_cycles got=%0d exp=4", en_cnt); end
    checks++; if (bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 8'h00 || bus.sel !== 2'd0 || bus.enable !== 1'b0) begin
      failures++; $display("FAIL to_rsp got err=%b rdata=%h sel=%0d enable=%b exp 1/00/0/0", bus.rsp_error, bus.rsp_rdata, bus.sel, bus.enable);
    end
    bus.rdata = 8'h00;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_invalid_id();
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_id = 2'd0; bus.req_addr = 8'h20; bus.req_wdata = 8'h11;
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 8'h00) begin
      failures++; $display("FAIL inv_rsp got valid=%b err=%b rdata=%h exp 1/1/00", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata);
    end
    checks++; if (bus.sel !== 2'd0 || bus.enable !== 1'b0) begin
      failures++; $display("FAIL inv_bus got sel=%0d enable=%b exp 0/0", bus.sel, bus.enable);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL inv_done got rsp_valid=%b req_ready=%b exp 0/1", bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_id = 2'd1; bus.req_addr = 8'h22;
    tick();
    bus.req_valid = 1'b0;
    bus.ready = 1'b1; bus.rdata = 8'hC3;
    tick();
    tick();
    bus.ready = 1'b0; bus.rdata = 8'h00;
    // A competing command during the held response must not start a transfer.
    bus.req_valid = 1'b1; bus.req_id = 2'd2; bus.req_addr = 8'h99;
    for (int i = 0; i < 5; i++) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'hC3 || bus.req_ready !== 1'b0 ||
          bus.sel !== 2'd0 || bus.enable !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_cycle%0d got valid=%b rdata=%h req_ready=%b sel=%0d enable=%b exp 1/C3/0/0/0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, bus.sel, bus.enable);
      end
      tick();
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold got bad_cycles=%0d exp=0", bad); end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got rsp_valid=%b req_ready=%b exp 0/1", bus.rsp_valid, bus.req_ready);
    end
    tick();
    checks++; if (bus.sel !== 2'd0 || bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL bp_no_stale got sel=%0d req_ready=%b exp 0/1", bus.sel, bus.req_ready);
    end
  endtask

  task automatic test_reset_access();
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_id = 2'd2; bus.req_addr = 8'h70; bus.req_wdata = 8'h3E;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    checks++; if (bus.enable !== 1'b1 || bus.sel !== 2'd2) begin
      failures++; $display("FAIL rst_pre got enable=%b sel=%0d exp 1/2", bus.enable, bus.sel);
    end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.sel !== 2'd0 || bus.enable !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rst_async got sel=%0d enable=%b rsp_valid=%b exp 0/0/0", bus.sel, bus.enable, bus.rsp_valid);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL rst_dropped got rsp_valid=%b req_ready=%b exp 0/1", bus.rsp_valid, bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_id = 2'd1; bus.req_addr = 8'h44;
    tick();
    bus.req_valid = 1'b0;
    bus.ready = 1'b1; bus.rdata = 8'h99;
    tick();
    tick();
    bus.ready = 1'b0; bus.rdata = 8'h00;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'h99 || bus.rsp_error !== 1'b0) begin
      failures++; $display("FAIL rst_after_read got valid=%b rdata=%h err=%b exp 1/99/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_error);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_invalid_id();
    test_backpressure();
    test_reset_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
